// File: rtl/core_seq.sv
// core_seq: multi-cycle fetch/decode/exec/mem/wb sequencer with PC control,
// halt, memory-ack timeout fault and retired-instruction counter.
module core_seq #(
    parameter int AW      = 8,
    parameter int TIMEOUT = 15,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          halt_req,
    output logic          imem_req,
    input  logic          imem_ack,
    output logic          ir_load,
    input  logic          dec_is_load,
    input  logic          dec_is_store,
    input  logic          dec_is_branch,
    input  logic          dec_is_jump,
    input  logic          dec_wb,
    input  logic          br_taken,
    input  logic [AW-1:0] br_target,
    output logic          dmem_req,
    output logic          dmem_we,
    input  logic          dmem_ack,
    output logic          rf_we,
    output logic          pc_inc,
    output logic          pc_load,
    output logic [AW-1:0] pc_target,
    output logic          busy,
    output logic          fault,
    output logic [2:0]    state,
    output logic [CW-1:0] instr_cnt
);
    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                           S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6, S_FAULT = 3'd7;
    localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [2:0]    state_q, state_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic          ld_q, ld_d, st_q, st_d, br_q, br_d, jmp_q, jmp_d, wb_q, wb_d, tk_q, tk_d;
    logic [AW-1:0] tgt_q, tgt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          expired, taken, redirect, retire;
    logic [2:0]    done_s;

    // Branch outcome is live in EXEC so a no-writeback branch can retire there.
    assign expired  = (TIMEOUT != 0) && (int'(wcnt_q) == TIMEOUT);
    assign taken    = (state_q == S_EXEC) ? br_taken : tk_q;
    assign redirect = jmp_q || (br_q && taken);
    assign retire   = (state_q == S_EXEC && !ld_q && !st_q && !wb_q) ||
                      (state_q == S_MEM && dmem_ack && st_q) || (state_q == S_WB);
    assign done_s   = halt_req ? S_HALT : S_FETCH;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            {ld_q, st_q, br_q, jmp_q, wb_q, tk_q} <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            {ld_q, st_q, br_q, jmp_q, wb_q, tk_q} <= {ld_d, st_d, br_d, jmp_d, wb_d, tk_d};
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HALT: state_d = start ? S_FETCH : state_q;
            S_FETCH:        state_d = imem_ack ? S_DECODE : expired ? S_FAULT : S_FETCH;
            S_DECODE:       state_d = (dec_is_load && dec_is_store) ? S_FAULT : S_EXEC;
            S_EXEC:         state_d = (ld_q || st_q) ? S_MEM : wb_q ? S_WB : done_s;
            S_MEM:          state_d = dmem_ack ? (ld_q ? S_WB : done_s) : expired ? S_FAULT : S_MEM;
            S_WB:           state_d = done_s;
            default:        state_d = state_q;
        endcase
        wcnt_d = (state_d == state_q && (state_q == S_FETCH || state_q == S_MEM)) ? wcnt_q + 1'b1 : '0;
        {ld_d, st_d, br_d, jmp_d, wb_d} = (state_q == S_DECODE) ?
            {dec_is_load, dec_is_store, dec_is_branch, dec_is_jump, dec_wb} : {ld_q, st_q, br_q, jmp_q, wb_q};
        tk_d  = (state_q == S_EXEC) ? br_taken : tk_q;
        tgt_d = (state_q == S_EXEC) ? br_target : tgt_q;
        cnt_d = cnt_q + (retire ? 1'b1 : 1'b0);
    end

    always_comb begin
        imem_req  = state_q == S_FETCH;
        ir_load   = state_q == S_FETCH && imem_ack;
        dmem_req  = state_q == S_MEM;
        dmem_we   = state_q == S_MEM && st_q;
        rf_we     = state_q == S_WB;
        pc_inc    = retire && !redirect;
        pc_load   = retire && redirect;
        pc_target = (state_q == S_EXEC) ? br_target : tgt_q;
        busy      = state_q >= S_FETCH && state_q <= S_WB;
        fault     = state_q == S_FAULT;
        state     = state_q;
        instr_cnt = cnt_q;
    end
endmodule

// File: tb/tb_core_seq.sv
// tb_core_seq: scoreboard bench for core_seq; a CW=4 copy shares the stimulus
// to exercise counter wrap.
module tb_core_seq;
    logic clk = 0, rst = 1, start = 0, halt_req = 0, imem_ack = 0, dmem_ack = 0;
    logic dec_is_load = 0, dec_is_store = 0, dec_is_branch = 0, dec_is_jump = 0, dec_wb = 0, br_taken = 0;
    logic [7:0] br_target = 0;
    logic imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_inc, pc_load, busy, fault;
    logic [7:0] pc_target;
    logic [2:0] state;
    logic [15:0] instr_cnt;
    logic imem_req_4, ir_load_4, dmem_req_4, dmem_we_4, rf_we_4, pc_inc_4, pc_load_4, busy_4, fault_4;
    logic [7:0] pc_target_4;
    logic [2:0] state_4;
    logic [3:0] instr_cnt_4;

    typedef struct {
        logic pcl;
        logic [7:0] tgt;
        int cyc;
        int rf;
        int mreq;
        logic we;
    } exp_t;
    exp_t sb[$];
    int tests = 0, fails = 0, cnt = 0;

    always #5 clk = ~clk;

    core_seq dut (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
        .imem_req(imem_req), .imem_ack(imem_ack), .ir_load(ir_load),
        .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_is_branch(dec_is_branch),
        .dec_is_jump(dec_is_jump), .dec_wb(dec_wb), .br_taken(br_taken), .br_target(br_target),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .rf_we(rf_we),
        .pc_inc(pc_inc), .pc_load(pc_load), .pc_target(pc_target), .busy(busy),
        .fault(fault), .state(state), .instr_cnt(instr_cnt)
    );

    core_seq #(.CW(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
        .imem_req(imem_req_4), .imem_ack(imem_ack), .ir_load(ir_load_4),
        .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_is_branch(dec_is_branch),
        .dec_is_jump(dec_is_jump), .dec_wb(dec_wb), .br_taken(br_taken), .br_target(br_target),
        .dmem_req(dmem_req_4), .dmem_we(dmem_we_4), .dmem_ack(dmem_ack), .rf_we(rf_we_4),
        .pc_inc(pc_inc_4), .pc_load(pc_load_4), .pc_target(pc_target_4), .busy(busy_4),
        .fault(fault_4), .state(state_4), .instr_cnt(instr_cnt_4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset_dut();
        rst = 1;
        {start, halt_req, imem_ack, dmem_ack, dec_is_load, dec_is_store, dec_is_branch, dec_is_jump, dec_wb, br_taken} = '0;
        br_target = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        cnt = 0;
        sb.delete();
    endtask

    task automatic go();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int lim, output int n);
        n = 0;
        while (state == s && n < lim) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Runs one instruction from a FETCH negedge with a responsive memory model.
    task automatic do_instr(input logic ld, st, br, jmp, wb, tk, input logic [7:0] tgt, input int dly, input logic halt);
        exp_t e, g;
        int cyc = 0, rf = 0, mreq = 0, ir = 0, mw = 0;
        logic we = 0;
        bit done = 0;
        {dec_is_load, dec_is_store, dec_is_branch, dec_is_jump, dec_wb, br_taken} = {ld, st, br, jmp, wb, tk};
        br_target = tgt;
        e.pcl = jmp | (br & tk);
        e.tgt = tgt;
        e.rf = int'(ld | (!st & wb));
        e.mreq = (ld | st) ? dly + 1 : 0;
        e.cyc = 3 + e.mreq + e.rf;
        e.we = st;
        sb.push_back(e);
        while (!done && cyc < 100) begin
            imem_ack = state == 3'd1;
            dmem_ack = state == 3'd4 && mw == dly;
            #1;
            cyc++;
            ir += int'(ir_load);
            rf += int'(rf_we);
            if (dmem_req) begin
                mreq++;
                mw++;
                we |= dmem_we;
            end
            if (pc_inc | pc_load) begin
                done = 1;
                g = sb.pop_front();
                cnt++;
                check("pc_load", pc_load, g.pcl);
                check("pc_inc", pc_inc, !g.pcl);
                if (g.pcl) check("pc_target", pc_target, g.tgt);
                check("cycles", cyc, g.cyc);
                check("rf_we_cycles", rf, g.rf);
                check("dmem_req_cycles", mreq, g.mreq);
                check("dmem_we", we, g.we);
                check("ir_load_cycles", ir, 1);
                halt_req = halt;
            end else @(negedge clk);
        end
        if (!done) begin
            check("retire_seen", 0, 1);
            g = sb.pop_front();
        end
        @(posedge clk);
        #1;
        check("instr_cnt", instr_cnt, cnt & 16'hFFFF);
        check("instr_cnt_cw4", instr_cnt_4, cnt & 4'hF);
        check("next_state", state, halt ? 3'd6 : 3'd1);
        @(negedge clk);
        halt_req = 0;
        {imem_ack, dmem_ack} = '0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int n;
        reset_dut();
        check("rst_outputs", {imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_inc, pc_load, pc_target, busy, fault, state, instr_cnt}, 0);
        go();
        check("start_fetch", state, 1);
        check("fetch_busy", busy, 1);
        do_instr(0, 0, 0, 0, 1, 0, 8'h00, 0, 0);
        do_instr(0, 0, 1, 0, 0, 1, 8'h3C, 0, 0);
        do_instr(0, 0, 1, 0, 0, 0, 8'h3C, 0, 1);
        check("halt_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("halt_cnt", instr_cnt, 3);
        check("halt_state", state, 6);
        check("halt_imem_req", imem_req, 0);
        start = 1;
        halt_req = 1;
        @(negedge clk);
        start = 0;
        halt_req = 0;
        check("start_beats_halt", state, 1);
        do_instr(1, 0, 0, 0, 1, 0, 8'h11, 3, 0);
        do_instr(0, 1, 0, 0, 0, 0, 8'h22, 0, 0);
        do_instr(0, 0, 0, 1, 1, 0, 8'h5A, 0, 0);
        do_instr(0, 1, 0, 0, 1, 0, 8'h00, 1, 0);
        for (int i = 0; i < 10; i++) begin
            logic [7:0] t;
            int d;
            t = 8'($urandom_range(0, 255));
            d = int'($urandom_range(0, 4));
            case (i % 5)
                0: do_instr(0, 0, 0, 0, 1, 0, t, 0, 0);
                1: do_instr(0, 0, 1, 0, 0, 1, t, 0, 0);
                2: do_instr(1, 0, 0, 0, 1, 0, t, d, 0);
                3: do_instr(0, 1, 1, 0, 0, 1, t, d, 0);
                default: do_instr(0, 0, 0, 0, 0, 0, t, 0, 0);
            endcase
        end
        check("cw4_wrap_17", instr_cnt_4, 1);
        {dec_is_load, dec_is_store, dec_is_branch, dec_is_jump, dec_wb} = 5'b10001;
        n = 0;
        while (state != 3'd4 && n < 20) begin
            imem_ack = state == 3'd1;
            @(negedge clk);
            n++;
        end
        check("reach_mem", state, 4);
        rst = 1;
        imem_ack = 0;
        @(negedge clk);
        rst = 0;
        cnt = 0;
        check("rst_mid_mem", {imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_inc, pc_load, pc_target, busy, fault, state, instr_cnt}, 0);
        go();
        {dec_is_load, dec_is_store} = 2'b11;
        imem_ack = 1;
        wait_state(3'd1, 20, n);
        wait_state(3'd2, 20, n);
        check("ldst_conflict_state", state, 7);
        check("ldst_conflict_fault", fault, 1);
        check("fault_no_req", {imem_req, dmem_req, rf_we, busy}, 0);
        reset_dut();
        go();
        wait_state(3'd1, 100, n);
        check("fetch_timeout_cycles", n, 16);
        check("fetch_timeout_state", state, 7);
        start = 1;
        @(negedge clk);
        start = 0;
        check("fault_sticky", fault, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("fault_rst_state", state, 0);
        check("fault_rst_flag", fault, 0);
        go();
        dec_is_load = 1;
        imem_ack = 1;
        wait_state(3'd1, 20, n);
        imem_ack = 0;
        wait_state(3'd2, 20, n);
        wait_state(3'd3, 20, n);
        wait_state(3'd4, 100, n);
        check("mem_timeout_cycles", n, 16);
        check("mem_timeout_state", state, 7);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/core_seq.md
Name: core_seq

Overview:
Multi-cycle sequencer for the RISC-V core. It steps each instruction through fetch, decode, execute, memory and writeback, and handshakes with instruction and data memory. It drives the program-counter control: one increment or one branch-load pulse per retired instruction. It also provides halt, memory-timeout fault detection and a retired-instruction counter.

Parameters:
AW, 8, program-counter / branch-target width
TIMEOUT, 15, max wait cycles for a memory ack before FAULT; 0 disables the timeout
CW, 16, retired-instruction counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  leave IDLE/HALT and begin fetching
halt_req  in  1  stop after the current instruction retires
imem_req  out  1  instruction fetch request
imem_ack  in  1  instruction memory data valid
ir_load  out  1  load instruction register (imem_req & imem_ack)
dec_is_load  in  1  decoded load, valid in DECODE
dec_is_store  in  1  decoded store, valid in DECODE
dec_is_branch  in  1  decoded conditional branch, valid in DECODE
dec_is_jump  in  1  decoded unconditional jump, valid in DECODE
dec_wb  in  1  instruction writes rd, valid in DECODE
br_taken  in  1  branch condition, valid in EXEC
br_target  in  AW  branch/jump target, valid in EXEC
dmem_req  out  1  data memory request
dmem_we  out  1  data write (store)
dmem_ack  in  1  data memory ack
rf_we  out  1  register file write enable
pc_inc  out  1  PC increment pulse
pc_load  out  1  PC load pulse
pc_target  out  AW  PC load value
busy  out  1  1 in FETCH..WB
fault  out  1  sticky fault flag
state  out  3  current state encoding
instr_cnt  out  CW  retired-instruction count

Behaviour:
- Reset value of every output is 0; state = IDLE.
- rst asserted in any state (including mid-instruction) returns to IDLE next edge and clears all registers and counters.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
- IDLE: start=1 -> FETCH.
- FETCH:
  - imem_req=1 for the whole state.
  - imem_ack=1 -> ir_load=1 that cycle, then DECODE.
- DECODE:
  - Exactly 1 cycle; latches the dec_* flags.
  - dec_is_load & dec_is_store both 1 -> FAULT; otherwise -> EXEC.
- EXEC:
  - Exactly 1 cycle; registers br_taken and br_target into pc_target.
  - load or store -> MEM.
  - else dec_wb -> WB.
  - else retire this cycle.
- MEM:
  - dmem_req=1 and dmem_we=is_store, held until ack.
  - dmem_ack with load -> WB; dmem_ack with store -> retire this cycle.
- WB: rf_we=1 for exactly 1 cycle, then retire.
- Retire cycle (the final cycle of an instruction):
  - if is_jump | (is_branch & taken): pc_load=1 and pc_target=latched target; else pc_inc=1.
  - pc_inc and pc_load are never both 1, and exactly one pulse is issued per instruction.
  - instr_cnt increments by 1 and wraps at 2^CW.
  - Next state is HALT if halt_req=1 in the retire cycle, else FETCH.
- HALT:
  - No requests issued; busy=0; instr_cnt is held.
  - start=1 -> FETCH.
  - start=1 and halt_req=1 together -> FETCH (start wins).
- FAULT:
  - fault=1, all request and enable outputs 0.
  - Only rst exits FAULT.
- Timeout (FETCH and MEM only):
  - Wait counter is cleared on state entry and counts each cycle without ack.
  - An ack in wait cycle k (0-based) is accepted for k <= TIMEOUT.
  - No ack by cycle TIMEOUT -> FAULT next edge.
  - TIMEOUT=0 means wait forever.
- imem_ack/dmem_ack outside their request states are ignored.
- start in states other than IDLE/HALT is ignored.
- Dec flags outside DECODE and br_taken/br_target outside EXEC are ignored.
- Latency, zero-wait memory:
  - ALU op with wb: 4 cycles (F,D,E,W).
  - Branch/jump without wb: 3 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
- busy=1 exactly in states 1..5.

Test Plan:
- Reset, then start=1 with imem_ack=1 every cycle and an ALU op (dec_wb=1) -> state sequence 1,2,3,5,1; rf_we high in cycle 4 only; pc_inc pulse in the same cycle; instr_cnt=1.
- Branch with br_taken=1 and br_target=8'h3C, no wb -> pc_load=1 and pc_target=8'h3C in the EXEC cycle, pc_inc=0. Repeat with br_taken=0 -> pc_inc=1 instead.
- Load with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles with dmem_we=0, then WB with rf_we=1. Store with an immediate ack -> dmem_we=1, retires in the MEM cycle, no rf_we.
- TIMEOUT=15 and imem_ack held 0 -> FAULT entered after 16 FETCH cycles; fault stays 1 despite start; rst -> IDLE, fault=0.
- halt_req=1 during the retire cycle of the 3rd instruction -> HALT, busy=0, instr_cnt=3. start=1 -> FETCH, counting resumes from 3.
- dec_is_load=dec_is_store=1 -> FAULT. rst asserted while in MEM -> IDLE next edge, all outputs 0, instr_cnt=0. CW=4 with 17 retires -> instr_cnt=1.
